uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter UART_INPUT_CLK, default 100_000_000: input clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600: serial bit rate in bits/s.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 data_in  input  8  byte to transmit; sampled only when a frame starts.
REQ-006 tx_en  input  1  level-sensitive transmit request.
REQ-007 tx  output  1  serial line, idle high.
REQ-008 done  output  1  one-clk pulse at frame completion.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 Oversample tick SHALL be generated every DIV clocks, DIV = UART_INPUT_CLK/(16*baud_rate), integer-truncated (651 at defaults).
REQ-011 One bit period SHALL equal exactly 16 ticks = 16*DIV clocks (10416 clocks, 104160 ns at defaults).
REQ-012 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10 bit periods total.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1, busy=0; if tx_en=1 on a clock edge, data_in is latched into a shift register and the FSM moves to START.
REQ-015 On entering START, the tick divider and tick counter SHALL clear, so tx=0 and busy=1 from the clock after tx_en is sampled, lasting exactly one bit period.
REQ-016 START->DATA after 16 ticks; DATA drives the current bit (index 0..7) for 16 ticks each; after bit 7, ->STOP.
REQ-017 STOP: tx=1 for 16 ticks; on the final tick, done=1 for exactly one clock, busy=0 in that same cycle, and the FSM returns to IDLE.
REQ-018 tx SHALL be driven from a register (glitch-free).
REQ-019 data_in and tx_en changes during a frame SHALL be ignored; the latched byte is transmitted unchanged.
REQ-020 If tx_en is still high in IDLE after done, the next frame SHALL start immediately, giving back-to-back frames with no idle gap beyond one clock.
REQ-021 tx_en deasserted mid-frame SHALL NOT abort the frame.
REQ-022 An internal register transmitted_current (4 bits, 0..9) SHALL hold the index of the bit currently on tx (0=start, 1..8=data, 9=stop) for debug visibility.

Reset
REQ-023 When rst_n=0 at a clock edge: state=IDLE, tx=1, busy=0, done=0, and all counters and the shift register SHALL be cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame; tx returns high on the next edge with no done pulse.
REQ-025 After rst_n rises, a frame SHALL start on the first edge where tx_en=1.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE/START/DATA/STOP), frame constants (DATA_BITS=8, OVERSAMPLE=16) and the DIV computation function.
REQ-027 The tick generator SHALL be a sub-module uart_baud_gen (parameters UART_INPUT_CLK, baud_rate; inputs clk, rst_n, clear; output tick).
REQ-028 The FSM/shifter SHALL be an instance named fsm_controller inside uart_tx.

Verification
REQ-029 Reset low 3 clks, then tx_en=1, data_in=0xE6 -> tx sequence 0,0,1,1,0,0,1,1,1,1, each held 104160 ns; done pulses once, 1 clk wide, after 10 bit periods.
REQ-030 Same frame -> busy high from the clock after tx_en sampled until the done cycle; transmitted_current steps 0..9 once per bit period.
REQ-031 tx_en held high with data_in=0x4B changed to 0x00 mid-frame -> first frame carries 0x4B, second frame starts the clock after done and carries 0x00.
REQ-032 rst_n pulsed low for one clock during data bit 4 -> tx=1, busy=0 next clock, no done pulse; a new tx_en sends a full correct frame.
REQ-033 tx_en=1 for one clock only, data_in=0x55 -> complete frame 0,1,0,1,0,1,0,1,0,1 still sent; tx idle high afterwards.
REQ-034 Parameters UART_INPUT_CLK=16_000_000, baud_rate=1_000_000 -> DIV=1, bit period 16 clocks, frame 160 clocks.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM states, frame constants
// and the clock divider computation.
package uart_tx_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_IDX_W  = 4;
    // Bit index of the stop bit on the line (0 = start, 1..8 = data).
    localparam int unsigned STOP_IDX   = DATA_BITS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Clocks per oversample tick, truncated; never below one clock.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        int unsigned d;
        d = clk_hz / (OVERSAMPLE * baud);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit request / serial line bundle.
//   data_in : byte to send (master -> slave)
//   tx_en   : level-sensitive transmit request (master -> slave)
//   tx      : serial line, idle high (slave -> master)
//   done    : one-clock pulse at frame end (slave -> master)
//   busy    : frame in progress (slave -> master)
interface uart_tx_if;
    logic [7:0] data_in;
    logic       tx_en;
    logic       tx;
    logic       done;
    logic       busy;

    modport master (
        output data_in,
        output tx_en,
        input  tx,
        input  done,
        input  busy
    );

    modport slave (
        input  data_in,
        input  tx_en,
        output tx,
        output done,
        output busy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the divider phase (held while the transmitter idles)
//   tick       : registered tick, high for one clock every DIV clocks
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned UART_INPUT_CLK = 100_000_000,
    parameter int unsigned baud_rate      = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DIV   = calc_div(UART_INPUT_CLK, baud_rate);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_tick;

    // Phase counter: clocks elapsed since clear, modulo DIV.
    always_comb begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (clear || (r_cnt == CNT_W'(DIV - 1))) begin
            w_cnt_next = '0;
        end
    end

    // The tick is registered one clock ahead, so the first tick after clear
    // is consumed exactly DIV clocks later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == CNT_W'(DIV - 1));
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/uart_tx_fsm.sv
// Frame sequencer and shifter: start bit, 8 data bits LSB first, stop bit,
// each held for OVERSAMPLE ticks.
//   clk, rst_n : clock, synchronous active-low reset
//   tick       : oversample tick from the baud generator
//   data_in    : byte latched when a frame starts
//   tx_en      : transmit request, sampled only in IDLE
//   tx         : registered serial output
//   done       : one-clock pulse on the final stop-bit tick
//   busy       : high while a frame is in progress
//   clear_c    : holds the baud generator phase at zero while idle
module uart_tx_fsm
    import uart_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [7:0] data_in,
    input  logic       tx_en,
    output logic       tx,
    output logic       done,
    output logic       busy,
    output logic       clear_c
);

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [TICK_CNT_W-1:0]  r_tick_cnt;
    logic                   r_tx;
    logic                   r_done;
    logic                   r_busy;
    // Index of the bit currently on the line: 0 start, 1..8 data, 9 stop.
    logic [BIT_IDX_W-1:0]   transmitted_current;
    logic                   w_bit_end;

    assign w_bit_end = tick && (r_tick_cnt == TICK_CNT_W'(OVERSAMPLE - 1));
    assign clear_c   = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state             <= IDLE;
            r_shift             <= '0;
            r_tick_cnt          <= '0;
            transmitted_current <= '0;
            r_tx                <= 1'b1;
            r_done              <= 1'b0;
            r_busy              <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Tick counter wraps naturally after OVERSAMPLE ticks.
            if (tick) begin
                r_tick_cnt <= r_tick_cnt + TICK_CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    r_tx                <= 1'b1;
                    r_busy              <= 1'b0;
                    r_tick_cnt          <= '0;
                    transmitted_current <= '0;
                    if (tx_en) begin
                        r_shift <= data_in;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_tx                <= r_shift[0];
                        transmitted_current <= BIT_IDX_W'(1);
                        r_state             <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (transmitted_current == BIT_IDX_W'(DATA_BITS)) begin
                            r_tx                <= 1'b1;
                            transmitted_current <= BIT_IDX_W'(STOP_IDX);
                            r_state             <= STOP;
                        end else begin
                            r_shift             <= r_shift >> 1;
                            r_tx                <= r_shift[1];
                            transmitted_current <= transmitted_current + BIT_IDX_W'(1);
                        end
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter top: 8N1 frames at baud_rate from an UART_INPUT_CLK clock.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : uart_tx_if slave (data_in, tx_en in; tx, done, busy out)
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned UART_INPUT_CLK = 100_000_000,
    parameter int unsigned baud_rate      = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_if.slave    bus
);

    logic w_tick;
    logic w_clear;
    logic w_tx;
    logic w_done;
    logic w_busy;

    uart_baud_gen #(
        .UART_INPUT_CLK (UART_INPUT_CLK),
        .baud_rate      (baud_rate)
    ) u_baud_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    uart_tx_fsm fsm_controller (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (w_tick),
        .data_in (bus.data_in),
        .tx_en   (bus.tx_en),
        .tx      (w_tx),
        .done    (w_done),
        .busy    (w_busy),
        .clear_c (w_clear)
    );

    assign bus.tx   = w_tx;
    assign bus.done = w_done;
    assign bus.busy = w_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at DIV=2 (32 clocks per bit): directed and random frames
// checked against a bit-level frame model.
module tb_uart_tx;

    localparam int unsigned CLK_HZ = 32_000_000;
    localparam int unsigned BAUD   = 1_000_000;
    localparam int          BIT    = 16 * int'(CLK_HZ / (16 * BAUD));
    localparam int          FRAME  = 10 * BIT;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    uart_tx_if bus_if ();

    uart_tx #(
        .UART_INPUT_CLK (CLK_HZ),
        .baud_rate      (BAUD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level for bit position idx of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Caller has just requested a frame before a posedge; checks every clock
    // of the frame plus the done cycle. Optionally changes data_in or drops
    // tx_en at a given clock offset within the frame.
    task automatic frame(input logic [7:0] b, input int chg_at, input logic [7:0] chg_data,
                         input int drop_at);
        for (int m = 0; m < FRAME; m++) begin
            @(negedge clk);
            chk("tx",   32'(bus_if.tx),   32'(exp_bit(b, m / BIT)));
            chk("busy", 32'(bus_if.busy), 32'd1);
            chk("done", 32'(bus_if.done), 32'd0);
            chk("bitidx", 32'(dut.fsm_controller.transmitted_current), 32'(m / BIT));
            if (m == chg_at)  bus_if.data_in = chg_data;
            if (m == drop_at) bus_if.tx_en   = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus_if.done), 32'd1);
        chk("done_busy",  32'(bus_if.busy), 32'd0);
        chk("done_tx",    32'(bus_if.tx),   32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx",   32'(bus_if.tx),   32'd1);
            chk("idle_busy", 32'(bus_if.busy), 32'd0);
            chk("idle_done", 32'(bus_if.done), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] nd;
        int         len;
        int         chg;

        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        bus_if.tx_en   = 1'b0;
        bus_if.data_in = 8'h00;

        // Reset held for three clocks.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx",   32'(bus_if.tx),   32'd1);
            chk("rst_busy", 32'(bus_if.busy), 32'd0);
            chk("rst_done", 32'(bus_if.done), 32'd0);
        end
        rst_n = 1'b1;
        idle(2);

        // 0xE6, request held for one clock.
        bus_if.data_in = 8'hE6;
        bus_if.tx_en   = 1'b1;
        frame(8'hE6, 3, 8'h11, 0);
        idle(5);

        // 0x55, single-clock request.
        bus_if.data_in = 8'h55;
        bus_if.tx_en   = 1'b1;
        frame(8'h55, -1, 8'h00, 0);
        idle(5);

        // Back-to-back: request held, data changed mid-frame.
        bus_if.data_in = 8'h4B;
        bus_if.tx_en   = 1'b1;
        frame(8'h4B, 100, 8'h00, -1);
        frame(8'h00, -1, 8'h00, 0);
        idle(5);

        // Random bytes, random request length and mid-frame data changes.
        for (int i = 0; i < 4; i++) begin
            b   = 8'($urandom);
            nd  = 8'($urandom);
            len = int'($urandom_range(1, 200));
            chg = int'($urandom_range(0, FRAME - 1));
            bus_if.data_in = b;
            bus_if.tx_en   = 1'b1;
            frame(b, chg, nd, len - 1);
            idle(int'($urandom_range(1, 6)));
        end

        // Reset pulse during data bit 4 of 0x0F (line low there).
        bus_if.data_in = 8'h0F;
        bus_if.tx_en   = 1'b1;
        for (int m = 0; m < 5 * BIT + 5; m++) begin
            @(negedge clk);
            chk("pre_rst_tx", 32'(bus_if.tx), 32'(exp_bit(8'h0F, m / BIT)));
            if (m == 0) bus_if.tx_en = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_tx",   32'(bus_if.tx),   32'd1);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_done", 32'(bus_if.done), 32'd0);
        idle(FRAME + BIT);

        // Fresh frame after the aborted one.
        b = 8'($urandom);
        bus_if.data_in = b;
        bus_if.tx_en   = 1'b1;
        frame(b, -1, 8'h00, 0);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
